// File: rtl/hdlverifier_axi_pkg.sv
// ----------------------------------------------------------------------------
// hdlverifier_axi_pkg
//
// Purpose:
//   Shared definitions for the AXI4 slave memory. The package holds the burst
//   and response encodings, the write/read FSM state types, and two helpers.
//   next_addr steps a burst address by one beat. burst_illegal flags a burst
//   that the slave refuses to service.
//
// Contents:
//   BURST_FIXED/INCR/WRAP         AXI burst type encodings
//   RESP_OKAY/EXOKAY/SLVERR/DECERR AXI response encodings
//   wr_state_t, rd_state_t        FSM state enums
//   next_addr()                   per-beat address advance
//   burst_illegal()               size/burst/len legality check
// ----------------------------------------------------------------------------
package hdlverifier_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The address helpers work at this width; the top truncates to its own
    // address width.
    localparam int ADDR_CALC_W = 64;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

    // Address of the beat after 'addr'. A WRAP burst stays inside an aligned
    // window of (len+1) beats. Legal wrap lengths make that window a power of
    // two, so a simple mask selects the offset inside the window.
    function automatic logic [ADDR_CALC_W-1:0] next_addr(
        input logic [ADDR_CALC_W-1:0] addr,
        input logic [1:0]             burst,
        input logic [7:0]             len,
        input logic [2:0]             size
    );
        logic [ADDR_CALC_W-1:0] beatBytes;
        logic [ADDR_CALC_W-1:0] incrAddr;
        logic [ADDR_CALC_W-1:0] wrapMask;
        beatBytes = {{(ADDR_CALC_W-1){1'b0}}, 1'b1} << size;
        incrAddr  = addr + beatBytes;
        wrapMask  = (({{(ADDR_CALC_W-8){1'b0}}, len} + 1) << size) - 1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incrAddr;
            BURST_WRAP:  next_addr = (addr & ~wrapMask) | (incrAddr & wrapMask);
            default:     next_addr = addr;
        endcase
    endfunction

    // A burst is refused when the beat size differs from the bus width, when
    // it uses the reserved burst type, or when a WRAP length is unsupported.
    function automatic logic burst_illegal(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len,
        input logic [2:0] busSize
    );
        logic wrapLenBad;
        wrapLenBad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        burst_illegal = (size != busSize) ||
                        (burst == 2'b11) ||
                        ((burst == BURST_WRAP) && wrapLenBad);
    endfunction

endpackage

// File: rtl/hdlverifier_axi_slave_mem_sdpram.sv
// ----------------------------------------------------------------------------
// axi_slave_sdpram
//
// Purpose:
//   Single-clock simple-dual-port RAM. It has one write port with byte enables
//   and one registered read port. When a read and a write hit the same word in
//   the same cycle, the read returns the old contents. The array has no reset,
//   so its contents survive a reset of the surrounding logic.
//
// Ports:
//   i_clk     clock
//   i_wrEn    write enable
//   i_wrAddr  write word index
//   i_wrData  write data
//   i_wrBe    per-byte write enables
//   i_rdEn    read enable; o_rdData updates the following edge
//   i_rdAddr  read word index
//   o_rdData  registered read data, held while i_rdEn is low
// ----------------------------------------------------------------------------
module axi_slave_sdpram #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    parameter int IDX_W      = $clog2(NUM_WORDS)
) (
    input  logic                    i_clk,
    input  logic                    i_wrEn,
    input  logic [IDX_W-1:0]        i_wrAddr,
    input  logic [DATA_WIDTH-1:0]   i_wrData,
    input  logic [DATA_WIDTH/8-1:0] i_wrBe,
    input  logic                    i_rdEn,
    input  logic [IDX_W-1:0]        i_rdAddr,
    output logic [DATA_WIDTH-1:0]   o_rdData
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] r_rdData;

    // Byte-masked write and registered read share one clocked block. The
    // non-blocking update gives read-old-data on a same-word collision.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wrBe[b]) begin
                    r_mem[i_wrAddr][b*8 +: 8] <= i_wrData[b*8 +: 8];
                end
            end
        end
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/hdlverifier_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// hdlverifier_axi_slave_mem
//
// Purpose:
//   AXI4 slave memory that sits downstream of the JTAG-driven AXI master. It
//   services one write burst and one read burst at a time. The write and read
//   channels are independent FSMs. Both use an internal simple-dual-port RAM.
//   Supported bursts are FIXED, INCR and WRAP of up to 256 beats. Each burst
//   reports OKAY, SLVERR or DECERR.
//
// Ports:
//   aclk, areset                 clock; asynchronous active-high reset
//   s_aw* / s_awvalid/s_awready  write address channel
//   s_w*  / s_wvalid/s_wready    write data channel
//   s_bid/s_bresp/s_bvalid/s_bready  write response channel
//   s_ar* / s_arvalid/s_arready  read address channel
//   s_rid/s_rdata/s_rresp/s_rlast/s_rvalid/s_rready  read data channel
// ----------------------------------------------------------------------------
module hdlverifier_axi_slave_mem #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 1,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [ID_WIDTH-1:0]         s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                  s_awlen,
    input  logic [2:0]                  s_awsize,
    input  logic [1:0]                  s_awburst,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wlast,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [ID_WIDTH-1:0]         s_bid,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [ID_WIDTH-1:0]         s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                  s_arlen,
    input  logic [2:0]                  s_arsize,
    input  logic [1:0]                  s_arburst,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [ID_WIDTH-1:0]         s_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic                        s_rvalid,
    input  logic                        s_rready
);

    import hdlverifier_axi_pkg::*;

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);

    // ---------------------------------------------------------------- write
    wr_state_t                 r_wState;
    wr_state_t                 w_wNextState;
    logic [ID_WIDTH-1:0]       r_wId;
    logic [AXI_ADDR_WIDTH-1:0] r_wAddr;
    logic [7:0]                r_wLen;
    logic [1:0]                r_wBurst;
    logic                      r_wErr;
    logic                      r_wDecErr;
    logic                      r_wSlvErr;
    logic [8:0]                r_wBeatCnt;

    logic                      w_awAccept;
    logic                      w_wBeat;
    logic                      w_wOutOfRange;
    logic                      w_wInBurst;
    logic                      w_wRamEn;
    logic [AXI_ADDR_WIDTH-1:0] w_wAddrNext;

    assign w_awAccept    = (r_wState == W_IDLE) && s_awvalid;
    assign w_wBeat       = (r_wState == W_DATA) && s_wvalid;
    // Any address bit above the RAM's index field means the beat is past the
    // end of the memory.
    assign w_wOutOfRange = |r_wAddr[AXI_ADDR_WIDTH-1:SZ+IDX_W];
    assign w_wInBurst    = r_wBeatCnt <= {1'b0, r_wLen};
    assign w_wRamEn      = w_wBeat && !r_wErr && !w_wOutOfRange && w_wInBurst;
    assign w_wAddrNext   = AXI_ADDR_WIDTH'(next_addr(ADDR_CALC_W'(r_wAddr),
                                                     r_wBurst, r_wLen, 3'(SZ)));

    // Write FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wNextState;
        end
    end

    // Write FSM next state. The FSM accepts an address, collects beats until
    // wlast, then holds the response until the master takes it.
    always_comb begin
        w_wNextState = r_wState;
        case (r_wState)
            W_IDLE:  if (s_awvalid)            w_wNextState = W_DATA;
            W_DATA:  if (s_wvalid && s_wlast)  w_wNextState = W_RESP;
            W_RESP:  if (s_bready)             w_wNextState = W_IDLE;
            default:                           w_wNextState = W_IDLE;
        endcase
    end

    // Write channel outputs. DECERR takes priority over SLVERR, and SLVERR
    // covers both a refused burst and a wrong beat count.
    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        s_bid     = r_wId;
        case (r_wState)
            W_IDLE: s_awready = 1'b1;
            W_DATA: s_wready  = 1'b1;
            W_RESP: begin
                s_bvalid = 1'b1;
                if (r_wDecErr) begin
                    s_bresp = RESP_DECERR;
                end else if (r_wSlvErr || r_wErr) begin
                    s_bresp = RESP_SLVERR;
                end else begin
                    s_bresp = RESP_OKAY;
                end
            end
            default: s_awready = 1'b0;
        endcase
    end

    // Write burst bookkeeping: latch the AW fields, step the address each
    // beat, and collect the error flags that decide the response. The beat
    // counter saturates so a runaway burst cannot wrap back into range.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wId      <= '0;
            r_wAddr    <= '0;
            r_wLen     <= '0;
            r_wBurst   <= BURST_FIXED;
            r_wErr     <= 1'b0;
            r_wDecErr  <= 1'b0;
            r_wSlvErr  <= 1'b0;
            r_wBeatCnt <= '0;
        end else if (w_awAccept) begin
            r_wId      <= s_awid;
            r_wAddr    <= s_awaddr;
            r_wLen     <= s_awlen;
            r_wBurst   <= s_awburst;
            r_wErr     <= burst_illegal(s_awsize, s_awburst, s_awlen, 3'(SZ));
            r_wDecErr  <= 1'b0;
            r_wSlvErr  <= 1'b0;
            r_wBeatCnt <= '0;
        end else if (w_wBeat) begin
            if (w_wOutOfRange) begin
                r_wDecErr <= 1'b1;
            end
            if (!w_wInBurst) begin
                r_wSlvErr <= 1'b1;
            end
            if (s_wlast && (r_wBeatCnt != {1'b0, r_wLen})) begin
                r_wSlvErr <= 1'b1;
            end
            r_wAddr <= w_wAddrNext;
            if (r_wBeatCnt != 9'h1FF) begin
                r_wBeatCnt <= r_wBeatCnt + 9'd1;
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_t                 r_rState;
    rd_state_t                 w_rNextState;
    logic [ID_WIDTH-1:0]       r_rId;
    logic [AXI_ADDR_WIDTH-1:0] r_rAddr;
    logic [7:0]                r_rLen;
    logic [1:0]                r_rBurst;
    logic                      r_rErr;
    logic [7:0]                r_rBeatCnt;

    logic                      w_arAccept;
    logic                      w_rRamEn;
    logic                      w_rOutOfRange;
    logic                      w_rBeatDone;
    logic [AXI_ADDR_WIDTH-1:0] w_rAddrNext;
    logic [AXI_DATA_WIDTH-1:0] w_ramRdData;

    assign w_arAccept    = (r_rState == R_IDLE) && s_arvalid;
    assign w_rRamEn      = (r_rState == R_FETCH);
    assign w_rOutOfRange = |r_rAddr[AXI_ADDR_WIDTH-1:SZ+IDX_W];
    assign w_rBeatDone   = (r_rState == R_DATA) && s_rready;
    assign w_rAddrNext   = AXI_ADDR_WIDTH'(next_addr(ADDR_CALC_W'(r_rAddr),
                                                     r_rBurst, r_rLen, 3'(SZ)));

    // Read FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rNextState;
        end
    end

    // Read FSM next state. Each beat costs one fetch cycle for the registered
    // RAM read and at least one presentation cycle. So the FSM bounces
    // between FETCH and DATA until the last beat is taken.
    always_comb begin
        w_rNextState = r_rState;
        case (r_rState)
            R_IDLE:  if (s_arvalid) w_rNextState = R_FETCH;
            R_FETCH:                w_rNextState = R_DATA;
            R_DATA: begin
                if (s_rready) begin
                    w_rNextState = (r_rBeatCnt == r_rLen) ? R_IDLE : R_FETCH;
                end
            end
            default:                w_rNextState = R_IDLE;
        endcase
    end

    // Read channel outputs. They come from registered state and the held RAM
    // output, so they stay stable while the master stalls. An out-of-range
    // beat returns zero data instead of the aliased RAM word.
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rresp   = RESP_OKAY;
        s_rdata   = '0;
        s_rid     = r_rId;
        case (r_rState)
            R_IDLE: s_arready = 1'b1;
            R_DATA: begin
                s_rvalid = 1'b1;
                s_rlast  = (r_rBeatCnt == r_rLen);
                if (r_rErr) begin
                    s_rresp = RESP_SLVERR;
                end else if (w_rOutOfRange) begin
                    s_rresp = RESP_DECERR;
                end else begin
                    s_rresp = RESP_OKAY;
                end
                if (!w_rOutOfRange) begin
                    s_rdata = w_ramRdData;
                end
            end
            default: s_arready = 1'b0;
        endcase
    end

    // Read burst bookkeeping: latch the AR fields, then step the address and
    // beat count as each beat is accepted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rId      <= '0;
            r_rAddr    <= '0;
            r_rLen     <= '0;
            r_rBurst   <= BURST_FIXED;
            r_rErr     <= 1'b0;
            r_rBeatCnt <= '0;
        end else if (w_arAccept) begin
            r_rId      <= s_arid;
            r_rAddr    <= s_araddr;
            r_rLen     <= s_arlen;
            r_rBurst   <= s_arburst;
            r_rErr     <= burst_illegal(s_arsize, s_arburst, s_arlen, 3'(SZ));
            r_rBeatCnt <= '0;
        end else if (w_rBeatDone && (r_rBeatCnt != r_rLen)) begin
            r_rAddr    <= w_rAddrNext;
            r_rBeatCnt <= r_rBeatCnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------ RAM
    axi_slave_sdpram #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .NUM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .i_clk    (aclk),
        .i_wrEn   (w_wRamEn),
        .i_wrAddr (r_wAddr[SZ +: IDX_W]),
        .i_wrData (s_wdata),
        .i_wrBe   (s_wstrb),
        .i_rdEn   (w_rRamEn),
        .i_rdAddr (r_rAddr[SZ +: IDX_W]),
        .o_rdData (w_ramRdData)
    );

endmodule

// File: tb/tb_hdlverifier_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_hdlverifier_axi_slave_mem
//
// Purpose:
//   Self-checking bench for the AXI4 slave memory (32-bit data, 1024 words).
//   Expected write responses and read beats are queued as each transaction is
//   issued. They are popped and compared as the DUT returns them.
// ----------------------------------------------------------------------------
module tb_hdlverifier_axi_slave_mem;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam int         TMO    = 50;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rdExp_t;

    logic        aclk;
    logic        areset;
    logic [0:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [0:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [0:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [0:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    int          checkCount = 0;
    int          errorCount = 0;
    rdExp_t      expRdQ[$];
    logic [1:0]  expBQ[$];
    logic [31:0] wData [16];
    logic [3:0]  wStrb [16];

    hdlverifier_axi_slave_mem #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .ID_WIDTH       (1),
        .MEM_WORDS      (1024)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    // 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Global watchdog so a wedged DUT still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives every DUT input to its idle value with reset held.
    task automatic applyStimulus();
        areset    = 1'b1;
        s_awid    = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd2;
        s_awburst = INCR; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready  = 1'b0;
        s_arid    = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd2;
        s_arburst = INCR; s_arvalid = 1'b0;
        s_rready  = 1'b0;
    endtask

    task automatic pushRead(input logic [31:0] data, input logic [1:0] resp,
                            input logic last);
        rdExp_t e;
        e.data = data; e.resp = resp; e.last = last;
        expRdQ.push_back(e);
    endtask

    // Issues one write burst of nBeats beats from wData/wStrb. wlast is set on
    // the final beat. Then it takes the response and compares it with the
    // scoreboard.
    task automatic writeBurst(input string name, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              input logic [2:0] size, input int nBeats,
                              input logic [1:0] expResp);
        int   t;
        logic [1:0] e;
        expBQ.push_back(expResp);
        @(negedge aclk);
        s_awvalid = 1'b1; s_awid = 1'b1; s_awaddr = addr; s_awlen = len;
        s_awburst = burst; s_awsize = size;
        t = 0;
        while (!s_awready && t < TMO) begin @(negedge aclk); t++; end
        if (!s_awready) checkOutput({name, "_aw_timeout"}, 64'(s_awready), 64'd1);
        @(negedge aclk);
        s_awvalid = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            s_wvalid = 1'b1; s_wdata = wData[i]; s_wstrb = wStrb[i];
            s_wlast  = (i == nBeats - 1);
            t = 0;
            while (!s_wready && t < TMO) begin @(negedge aclk); t++; end
            if (!s_wready) checkOutput({name, "_w_timeout"}, 64'(s_wready), 64'd1);
            @(negedge aclk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s_bready = 1'b1;
        t = 0;
        while (!s_bvalid && t < TMO) begin @(negedge aclk); t++; end
        if (!s_bvalid) begin
            checkOutput({name, "_b_timeout"}, 64'(s_bvalid), 64'd1);
        end else begin
            e = expBQ.pop_front();
            checkOutput({name, "_bresp"}, 64'(s_bresp), 64'(e));
            checkOutput({name, "_bid"}, 64'(s_bid), 64'd1);
        end
        @(negedge aclk);
        s_bready = 1'b0;
        checkOutput({name, "_awready_after_b"}, 64'(s_awready), 64'd1);
    endtask

    // Issues one read burst and checks each returned beat against the
    // scoreboard. It also checks the 2-cycle first-beat latency. With stall>0
    // rready is held low on the first beat, and the beat must stay stable.
    task automatic readBurst(input string name, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input int stall);
        int     t;
        rdExp_t e;
        @(negedge aclk);
        s_arvalid = 1'b1; s_arid = 1'b1; s_araddr = addr; s_arlen = len;
        s_arburst = burst; s_arsize = size;
        s_rready  = (stall == 0);
        t = 0;
        while (!s_arready && t < TMO) begin @(negedge aclk); t++; end
        if (!s_arready) checkOutput({name, "_ar_timeout"}, 64'(s_arready), 64'd1);
        @(negedge aclk);
        s_arvalid = 1'b0;
        t = 0;
        while (!s_rvalid && t < TMO) begin @(negedge aclk); t++; end
        checkOutput({name, "_first_latency"}, 64'(t), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            if (b > 0) begin
                t = 0;
                while (!s_rvalid && t < TMO) begin @(negedge aclk); t++; end
            end
            if (!s_rvalid) begin
                checkOutput({name, "_r_timeout"}, 64'(s_rvalid), 64'd1);
                break;
            end
            if (expRdQ.size() == 0) begin
                checkOutput({name, "_sb_empty"}, 64'(expRdQ.size()), 64'd1);
                break;
            end
            if (b == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge aclk);
                    checkOutput({name, "_stall_rvalid"}, 64'(s_rvalid), 64'd1);
                    checkOutput({name, "_stall_rdata"}, 64'(s_rdata), 64'(expRdQ[0].data));
                    checkOutput({name, "_stall_rlast"}, 64'(s_rlast), 64'(expRdQ[0].last));
                end
                s_rready = 1'b1;
            end
            e = expRdQ.pop_front();
            checkOutput({name, "_rdata"}, 64'(s_rdata), 64'(e.data));
            checkOutput({name, "_rresp"}, 64'(s_rresp), 64'(e.resp));
            checkOutput({name, "_rlast"}, 64'(s_rlast), 64'(e.last));
            checkOutput({name, "_rid"}, 64'(s_rid), 64'd1);
            @(negedge aclk);
        end
        s_rready = 1'b0;
        checkOutput({name, "_arready_idle"}, 64'(s_arready), 64'd1);
    endtask

    task automatic setBeat(input int i, input logic [31:0] d, input logic [3:0] s);
        wData[i] = d;
        wStrb[i] = s;
    endtask

    initial begin
        int t;
        applyStimulus();
        repeat (3) @(negedge aclk);

        // Reset values
        checkOutput("rst_awready", 64'(s_awready), 64'd1);
        checkOutput("rst_arready", 64'(s_arready), 64'd1);
        checkOutput("rst_wready",  64'(s_wready),  64'd0);
        checkOutput("rst_bvalid",  64'(s_bvalid),  64'd0);
        checkOutput("rst_rvalid",  64'(s_rvalid),  64'd0);
        checkOutput("rst_rlast",   64'(s_rlast),   64'd0);
        checkOutput("rst_bresp",   64'(s_bresp),   64'd0);
        checkOutput("rst_rresp",   64'(s_rresp),   64'd0);
        checkOutput("rst_rdata",   64'(s_rdata),   64'd0);
        areset = 1'b0;

        // INCR write then read back
        setBeat(0, 32'h11, 4'hF); setBeat(1, 32'h22, 4'hF);
        setBeat(2, 32'h33, 4'hF); setBeat(3, 32'h44, 4'hF);
        writeBurst("incr_wr", 32'h40, 8'd3, INCR, 3'd2, 4, OKAY);
        pushRead(32'h11, OKAY, 1'b0); pushRead(32'h22, OKAY, 1'b0);
        pushRead(32'h33, OKAY, 1'b0); pushRead(32'h44, OKAY, 1'b1);
        readBurst("incr_rd", 32'h40, 8'd3, INCR, 3'd2, 0);

        // WRAP write at 0x38: beats land at 0x38, 0x3C, 0x30, 0x34
        setBeat(0, 32'hA0, 4'hF); setBeat(1, 32'hA1, 4'hF);
        setBeat(2, 32'hA2, 4'hF); setBeat(3, 32'hA3, 4'hF);
        writeBurst("wrap_wr", 32'h38, 8'd3, WRAP, 3'd2, 4, OKAY);
        pushRead(32'hA0, OKAY, 1'b0); pushRead(32'hA1, OKAY, 1'b0);
        pushRead(32'hA2, OKAY, 1'b0); pushRead(32'hA3, OKAY, 1'b1);
        readBurst("wrap_rd", 32'h38, 8'd3, WRAP, 3'd2, 0);
        pushRead(32'hA2, OKAY, 1'b0); pushRead(32'hA3, OKAY, 1'b0);
        pushRead(32'hA0, OKAY, 1'b0); pushRead(32'hA1, OKAY, 1'b1);
        readBurst("wrap_lin_rd", 32'h30, 8'd3, INCR, 3'd2, 0);

        // Byte strobes over a zeroed word
        setBeat(0, 32'h0, 4'hF);
        writeBurst("strb_clr", 32'h80, 8'd0, INCR, 3'd2, 1, OKAY);
        setBeat(0, 32'hAABBCCDD, 4'b0101);
        writeBurst("strb_wr", 32'h80, 8'd0, INCR, 3'd2, 1, OKAY);
        pushRead(32'h00BB00DD, OKAY, 1'b1);
        readBurst("strb_rd", 32'h80, 8'd0, FIXED, 3'd2, 0);

        // Out of range: 0x1000 aliases word 0, which must stay untouched
        setBeat(0, 32'hCAFEF00D, 4'hF);
        writeBurst("w0_wr", 32'h0, 8'd0, INCR, 3'd2, 1, OKAY);
        setBeat(0, 32'h12345678, 4'hF);
        writeBurst("oor_wr", 32'h1000, 8'd0, INCR, 3'd2, 1, DECERR);
        pushRead(32'hCAFEF00D, OKAY, 1'b1);
        readBurst("w0_rd", 32'h0, 8'd0, INCR, 3'd2, 0);
        pushRead(32'h0, DECERR, 1'b1);
        readBurst("oor_rd", 32'h1000, 8'd0, INCR, 3'd2, 0);

        // Early wlast: len 3 but only two beats
        setBeat(0, 32'h55, 4'hF); setBeat(1, 32'h66, 4'hF);
        writeBurst("early_wr", 32'h100, 8'd3, INCR, 3'd2, 2, SLVERR);

        // Reserved burst type is refused and writes nothing
        setBeat(0, 32'hDEAD, 4'hF);
        writeBurst("bad_burst_wr", 32'h40, 8'd0, 2'b11, 3'd2, 1, SLVERR);
        pushRead(32'h11, OKAY, 1'b1);
        readBurst("bad_burst_rd", 32'h40, 8'd0, INCR, 3'd2, 0);

        // Overrun: len 1 with three beats; the third beat is dropped
        setBeat(0, 32'h0, 4'hF); setBeat(1, 32'h0, 4'hF); setBeat(2, 32'h0, 4'hF);
        writeBurst("ovr_clr", 32'h90, 8'd2, INCR, 3'd2, 3, OKAY);
        setBeat(0, 32'hB0, 4'hF); setBeat(1, 32'hB1, 4'hF); setBeat(2, 32'hB2, 4'hF);
        writeBurst("ovr_wr", 32'h90, 8'd1, INCR, 3'd2, 3, SLVERR);
        pushRead(32'hB0, OKAY, 1'b0); pushRead(32'hB1, OKAY, 1'b0);
        pushRead(32'h0, OKAY, 1'b1);
        readBurst("ovr_rd", 32'h90, 8'd2, INCR, 3'd2, 0);

        // rready held low for 5 cycles on the first beat
        pushRead(32'h11, OKAY, 1'b0); pushRead(32'h22, OKAY, 1'b0);
        pushRead(32'h33, OKAY, 1'b0); pushRead(32'h44, OKAY, 1'b1);
        readBurst("stall_rd", 32'h40, 8'd3, INCR, 3'd2, 5);

        // Reset in the middle of a read burst
        @(negedge aclk);
        s_arvalid = 1'b1; s_arid = 1'b1; s_araddr = 32'h40; s_arlen = 8'd7;
        s_arburst = INCR; s_arsize = 3'd2; s_rready = 1'b0;
        t = 0;
        while (!s_arready && t < TMO) begin @(negedge aclk); t++; end
        @(negedge aclk);
        s_arvalid = 1'b0;
        t = 0;
        while (!s_rvalid && t < TMO) begin @(negedge aclk); t++; end
        checkOutput("midrst_rvalid_before", 64'(s_rvalid), 64'd1);
        areset = 1'b1;
        #1;
        checkOutput("midrst_rvalid", 64'(s_rvalid), 64'd0);
        checkOutput("midrst_arready", 64'(s_arready), 64'd1);
        checkOutput("midrst_awready", 64'(s_awready), 64'd1);
        @(negedge aclk);
        areset = 1'b0;
        pushRead(32'h11, OKAY, 1'b1);
        readBurst("post_rst_rd", 32'h40, 8'd0, INCR, 3'd2, 0);

        checkOutput("sb_rd_drained", 64'(expRdQ.size()), 64'd0);
        checkOutput("sb_b_drained", 64'(expBQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hdlverifier_axi_slave_mem.md
Name: hdlverifier_axi_slave_mem

Overview:
- AXI4 slave memory that sits directly downstream of the JTAG-driven AXI master. It is the target the master's read/write bursts land on in loop-back and bring-up builds.
- Accepts one write burst and one read burst at a time. The two channels run independently, each with its own FSM.
- Supports FIXED, INCR and WRAP bursts up to 256 beats against an internal simple-dual-port RAM.
- Reports OKAY, SLVERR or DECERR per burst.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; only 32 or 64 are legal.
- AXI_ADDR_WIDTH, 32, byte address width.
- ID_WIDTH, 1, width of awid/arid/bid/rid.
- MEM_WORDS, 1024, RAM depth in data words; must be a power of 2.

Ports:
- aclk  in  1  clock for everything.
- areset  in  1  asynchronous, active-high reset.
- s_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel.
- s_awvalid  in  1;  s_awready  out  1.
- s_wdata/wstrb/wlast  in  DATA/DATA/8/1  write data channel.
- s_wvalid  in  1;  s_wready  out  1.
- s_bid  out  ID;  s_bresp  out  2;  s_bvalid  out  1;  s_bready  in  1.
- s_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address channel.
- s_arvalid  in  1;  s_arready  out  1.
- s_rid  out  ID;  s_rdata  out  DATA;  s_rresp  out  2;  s_rlast  out  1;  s_rvalid  out  1;  s_rready  in  1.

Behaviour:
- Constants: BYTES = AXI_DATA_WIDTH/8; SZ = log2(BYTES).
- Word index = addr[SZ +: log2(MEM_WORDS)].
- Decode error: addr >> SZ is at or above MEM_WORDS.
- Reset (async): awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp, rdata = 0; both FSMs in IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE, awready=1: on awvalid, latch id/addr/len/burst and compute an error flag, then go to W_DATA. awready=0 next cycle.
  - Error flag at AW: awsize != SZ, or awburst == 2'b11, or WRAP with len not in {1,3,7,15}.
  - W_DATA, wready=1: each wvalid beat writes the RAM with the wstrb byte enables at the current address, unless the burst is errored or the beat address decodes as out of range.
  - Address advance per beat: FIXED holds; INCR adds BYTES; WRAP adds BYTES and wraps inside an aligned window of (len+1)*BYTES bytes.
  - On the wlast beat, go to W_RESP.
  - Beat count != len+1 at wlast gives SLVERR. Beats past len+1 without wlast are written nowhere (dropped) and the response is SLVERR.
  - W_RESP: bvalid=1; bresp priority is DECERR (any beat out of range), then SLVERR, then OKAY. bvalid is held until bready, then W_IDLE with awready=1 the next cycle.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE, arready=1: on arvalid, latch fields, then go to R_FETCH. The arsize/arburst/len checks are the same as for writes.
  - R_FETCH: issue the RAM read (1-cycle latency), then go to R_DATA.
  - R_DATA: rvalid=1, rdata is the RAM output, rlast=1 on beat len.
  - rresp per beat: SLVERR if the burst is errored; else DECERR if the beat is out of range, with rdata=0; else OKAY.
  - On rvalid&rready: if rlast, go to R_IDLE; otherwise advance the address and return to R_FETCH.
  - Timing: first rvalid appears 2 cycles after the AR handshake. Steady state is 1 beat per 2 cycles.
  - rdata/rresp/rlast are stable while rvalid=1 and rready=0.
- Both channels may be active in the same cycle. A read and a write to the same word in the same cycle returns the OLD data.
- Reset asserted mid-burst: both FSMs return to IDLE immediately and the rest of the burst is abandoned. RAM contents are not cleared.

Decomposition:
- Package hdlverifier_axi_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP;
  - response constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the wr_state_t and rd_state_t enums;
  - function next_addr(addr, burst, len, size).
- Sub-module axi_slave_sdpram: single-clock, one write port with byte enables, one registered read port, no_rw_check style. The RAM holds no reset.

Test Plan:
- INCR write: addr 0x40, len 3, data 0x11..0x44, strb all ones → bresp OKAY. Then an INCR read of the same region → rdata 0x11,0x22,0x33,0x44, rlast on beat 3, first rvalid at cycle +2 after the AR handshake.
- WRAP, 32-bit: awaddr 0x38, len 3 → beats land at 0x38, 0x3C, 0x30, 0x34. Reading back with a WRAP read at 0x38 returns the same order.
- Byte strobe: write 0xAABBCCDD with strb 4'b0101 over a word holding 0 → read returns 0x00BB00DD.
- Out of range: MEM_WORDS=1024, 32-bit, write at 0x1000 → bresp DECERR and the RAM is unchanged. Read at 0x1000 → rresp DECERR, rdata 0.
- Early wlast: awlen 3 but wlast on beat 1 → bresp SLVERR, FSM back in IDLE, awready=1 one cycle after the bready handshake.
- rready held low for 5 cycles → rdata/rlast stay stable. Asserting areset mid-read drops rvalid at once and arready=1.
